// File: rtl/fp32_uart_tx_if.sv
// Handshake bundle between the MAC result producer and the FP32 UART transmitter.
// Latency: none, this is wiring only.
// Backpressure: the producer holds tx_vld/tx_dat until a cycle where tx_rdy is high.
interface fp32_uart_tx_if #(
  parameter int W = 32
);
  logic         tx_vld;
  logic [W-1:0] tx_dat;
  logic         tx_rdy;
  logic         tx_done;

  modport master (output tx_vld, output tx_dat, input tx_rdy, input tx_done);
  modport slave  (input tx_vld, input tx_dat, output tx_rdy, output tx_done);
endinterface

// File: rtl/fp32_uart_tx.sv
// Serialises one FP32 word as NUM_BYTES 8N1 frames, byte 0 first and LSB first within each byte.
// Latency: the start bit begins the cycle after accept; tx_done pulses NUM_BYTES*10*CLKS_PER_BIT cycles after accept.
// Backpressure: tx_rdy drops on the accept edge and returns the cycle after the done pulse; input changes while busy are ignored.
module fp32_uart_tx #(
  parameter int CLKS_PER_BIT = 443,
  parameter int NUM_BYTES    = 4
) (
  input  logic          CLK_I,
  input  logic          RSTL_I,
  fp32_uart_tx_if.slave tx_if,
  output logic          UART_TX_O
);
  localparam int DW     = 8 * NUM_BYTES;
  localparam int CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BYTE_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NUM_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   clk_cnt_q;
  logic [2:0]         bit_q;
  logic [BYTE_W-1:0]  byte_q;
  logic [DW-1:0]      shift_q;
  logic               tx_q;
  logic               rdy_q;
  logic               done_q;
  logic               bit_end_d;

  // The current bit period ends on this cycle.
  assign bit_end_d = (clk_cnt_q == CNT_LAST);

  assign UART_TX_O     = tx_q;
  assign tx_if.tx_rdy  = rdy_q;
  assign tx_if.tx_done = done_q;

  // Frame sequencer; every output is produced here so nothing combinational reaches the pins.
  // The shift register always presents the next data bit at bit 0, which yields byte 0 first, LSB first.
  always_ff @(posedge CLK_I or negedge RSTL_I) begin
    if (!RSTL_I) begin
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      rdy_q     <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_q      <= 1'b1;
          rdy_q     <= 1'b1;
          done_q    <= 1'b0;
          clk_cnt_q <= '0;
          bit_q     <= '0;
          byte_q    <= '0;
          if (tx_if.tx_vld && rdy_q) begin
            shift_q <= tx_if.tx_dat;
            rdy_q   <= 1'b0;
            tx_q    <= 1'b0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (bit_end_d) begin
            clk_cnt_q <= '0;
            bit_q     <= '0;
            tx_q      <= shift_q[0];
            shift_q   <= shift_q >> 1;
            state_q   <= S_DATA;
          end else begin
            clk_cnt_q <= clk_cnt_q + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (bit_end_d) begin
            clk_cnt_q <= '0;
            if (bit_q == 3'd7) begin
              bit_q   <= '0;
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end else begin
              bit_q   <= bit_q + 3'd1;
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (bit_end_d) begin
            clk_cnt_q <= '0;
            if (byte_q == BYTE_LAST) begin
              byte_q  <= '0;
              tx_q    <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              // Next frame follows immediately with its start bit.
              byte_q  <= byte_q + BYTE_W'(1);
              tx_q    <= 1'b0;
              state_q <= S_START;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CNT_W'(1);
          end
        end
        S_DONE: begin
          clk_cnt_q <= '0;
          bit_q     <= '0;
          byte_q    <= '0;
          shift_q   <= '0;
          tx_q      <= 1'b1;
          done_q    <= 1'b0;
          rdy_q     <= 1'b1;
          state_q   <= S_IDLE;
        end
        default: begin
          clk_cnt_q <= '0;
          bit_q     <= '0;
          byte_q    <= '0;
          shift_q   <= '0;
          tx_q      <= 1'b1;
          done_q    <= 1'b0;
          rdy_q     <= 1'b1;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end
endmodule
